// File: rtl/imem_multiport.sv
// Shared, loadable instruction memory with one registered read channel per core.
// After reset a sweep fills every word with a NOP. A loader port then writes the program.
// Each read channel returns a valid/error response one cycle after its request and
// keeps a sticky flag once a HALT instruction has been delivered to that core.
module imem_multiport #(
  parameter int              NCORES       = 4,
  parameter int              AW           = 5,
  parameter int              DW           = 32,
  parameter logic [29-AW:0]  BASE_ADDRESS = '0,
  parameter logic [DW-1:0]   NOP_WORD     = DW'(32'h0000F020),
  parameter logic [DW-1:0]   DEFAULT_WORD = DW'(32'h0000FFFF),
  parameter logic [5:0]      HALT_OP      = 6'd63
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 busy,
  input  logic                 ld_we,
  input  logic [AW-1:0]        ld_addr,
  input  logic [DW-1:0]        ld_data,
  output logic                 ld_ack,
  input  logic [NCORES-1:0]    rd_req,
  input  logic [NCORES*32-1:0] rd_addr,
  output logic [NCORES*DW-1:0] rd_data,
  output logic [NCORES-1:0]    rd_valid,
  output logic [NCORES-1:0]    rd_err,
  output logic [NCORES-1:0]    halt_seen
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          run;

  logic [DW-1:0]     mem [DEPTH];
  logic [NCORES-1:0] addr_bad;
  logic [DW-1:0]     fetch [NCORES];

  assign run  = (state == RUN);
  assign busy = (state == INIT);

  // State and sweep-counter register; reset restarts the NOP sweep from word 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: INIT walks every word once, then RUN holds until the next reset.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == LAST) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // Storage writes: the sweep owns the array during INIT, the loader owns it in RUN.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state == INIT)
        mem[cnt] <= NOP_WORD;
      else if (ld_we)
        mem[ld_addr] <= ld_data;
    end
  end

  // Per-channel address decode and array lookup; the window compare keeps
  // out-of-range addresses from aliasing onto a valid word.
  always_comb begin
    addr_bad = '0;
    for (int i = 0; i < NCORES; i++) begin
      addr_bad[i] = (rd_addr[32*i +: 2] != 2'b00) ||
                    (rd_addr[32*i+AW+2 +: 30-AW] != BASE_ADDRESS);
      fetch[i]    = mem[rd_addr[32*i+2 +: AW]];
    end
  end

  // Loader acknowledge: one-cycle pulse after each accepted write.
  always_ff @(posedge clk) begin
    if (!reset_n) ld_ack <= 1'b0;
    else          ld_ack <= run && ld_we;
  end

  // Read responses: sampled from the array before this edge's loader write lands,
  // so a same-word collision returns the old contents; idle channels hold data/err.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_valid  <= '0;
      rd_err    <= '0;
      rd_data   <= '0;
      halt_seen <= '0;
    end else begin
      rd_valid <= rd_req & {NCORES{run}};
      for (int i = 0; i < NCORES; i++) begin
        if (run && rd_req[i]) begin
          if (addr_bad[i]) begin
            rd_err[i]            <= 1'b1;
            rd_data[DW*i +: DW]  <= DEFAULT_WORD;
          end else begin
            rd_err[i]            <= 1'b0;
            rd_data[DW*i +: DW]  <= fetch[i];
            if (fetch[i][31:26] == HALT_OP) halt_seen[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_multiport.sv
// Bench for imem_multiport: directed steps followed by random traffic, all checked
// against a word-array reference model of the memory and its response rules.
module tb_imem_multiport;

  localparam int          NC  = 4;
  localparam logic [31:0] NOP = 32'h0000F020;
  localparam logic [31:0] DEF = 32'h0000FFFF;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         busy;
  logic         ld_we;
  logic [4:0]   ld_addr;
  logic [31:0]  ld_data;
  logic         ld_ack;
  logic [3:0]   rd_req;
  logic [127:0] rd_addr;
  logic [127:0] rd_data;
  logic [3:0]   rd_valid;
  logic [3:0]   rd_err;
  logic [3:0]   halt_seen;

  int checks = 0;
  int errors = 0;

  logic [31:0]  model_mem [32];
  logic [127:0] exp_data;
  logic [3:0]   exp_err;
  logic [3:0]   exp_halt;

  imem_multiport dut (
    .clk(clk), .reset_n(reset_n), .busy(busy),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err), .halt_seen(halt_seen)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    logic [31:0] a;
    k = $urandom_range(0, 9);
    if (k < 6)      a = $urandom_range(0, 31) * 4;
    else if (k < 8) a = $urandom_range(0, 31) * 4 + $urandom_range(1, 3);
    else            a = ($urandom | 32'h80) & 32'hFFFF_FFFC;
    return a;
  endfunction

  // Reference: a request returns DEFAULT/err for unaligned or >=128 byte addresses,
  // else the model word as it stood before this cycle's load; loads update afterwards.
  task automatic step(input logic [3:0] req, input logic [127:0] addr, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input string tag);
    logic [31:0] a;
    logic [31:0] w;
    rd_req = req; rd_addr = addr; ld_we = we; ld_addr = wa; ld_data = wd;
    for (int i = 0; i < NC; i++) begin
      if (req[i]) begin
        a = addr[32*i +: 32];
        if ((a % 4) != 0 || a >= 32'd128) begin
          exp_err[i] = 1'b1;
          exp_data[32*i +: 32] = DEF;
        end else begin
          w = model_mem[a / 4];
          exp_err[i] = 1'b0;
          exp_data[32*i +: 32] = w;
          if (w[31:26] == 6'd63) exp_halt[i] = 1'b1;
        end
      end
    end
    if (we) model_mem[wa] = wd;
    tick();
    rd_req = '0; ld_we = 1'b0;
    chk({tag, "_valid"}, 128'(rd_valid), 128'(req));
    chk({tag, "_data"}, rd_data, exp_data);
    chk({tag, "_err"}, 128'(rd_err), 128'(exp_err));
    chk({tag, "_ack"}, 128'(ld_ack), 128'(we));
    chk({tag, "_halt"}, 128'(halt_seen), 128'(exp_halt));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  task automatic do_reset(input int hold, input logic [3:0] req);
    reset_n = 1'b0; rd_req = req; rd_addr = {4{32'h20}}; ld_we = 1'b0;
    repeat (hold) tick();
    rd_req = '0;
    exp_data = '0; exp_err = '0; exp_halt = '0;
    for (int i = 0; i < 32; i++) model_mem[i] = NOP;
    chk("rst_busy", 128'(busy), 128'(1));
    chk("rst_valid", 128'(rd_valid), 128'(0));
    chk("rst_ack", 128'(ld_ack), 128'(0));
    chk("rst_halt", 128'(halt_seen), 128'(0));
    chk("rst_data", rd_data, 128'(0));
    chk("rst_err", 128'(rd_err), 128'(0));
  endtask

  // Counts busy cycles while hammering the ignored read and load ports.
  task automatic wait_sweep(output int n);
    n = 0;
    rd_req = '1; rd_addr = {4{32'h20}};
    ld_we = 1'b1; ld_addr = 5'd8; ld_data = 32'hDEADBEEF;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
      chk("init_valid", 128'(rd_valid), 128'(0));
      chk("init_ack", 128'(ld_ack), 128'(0));
      chk("init_data", rd_data, exp_data);
    end
    rd_req = '0; ld_we = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] wd;
    reset_n = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    rd_req = '0; rd_addr = '0;
    exp_data = '0; exp_err = '0; exp_halt = '0;

    // 1: long reset, sweep length, NOP at the last word
    do_reset(40, 4'h0);
    reset_n = 1'b1;
    wait_sweep(n);
    chk("sweep_len", 128'(n), 128'(32));
    step(4'b0001, {96'd0, 32'h7C}, 1'b0, 5'd0, 32'd0, "t1");
    chk("t1_word", 128'(rd_data[31:0]), 128'(32'h0000F020));
    chk("t1_err0", 128'(rd_err[0]), 128'(0));

    // 2: load then read back on core 2
    step(4'b0000, 128'd0, 1'b1, 5'd8, 32'h8C030080, "t2w");
    step(4'b0100, {32'h0, 32'h20, 64'h0}, 1'b0, 5'd0, 32'd0, "t2r");
    chk("t2_word", 128'(rd_data[95:64]), 128'(32'h8C030080));

    // 3: unaligned and out-of-window requests in the same cycle
    step(4'b1010, {32'h80, 32'h0, 32'h22, 32'h0}, 1'b0, 5'd0, 32'd0, "t3");
    chk("t3_err", 128'({rd_err[3], rd_err[1]}), 128'(2'b11));
    chk("t3_d1", 128'(rd_data[63:32]), 128'(32'h0000FFFF));
    chk("t3_d3", 128'(rd_data[127:96]), 128'(32'h0000FFFF));
    chk("t3_idle", 128'({rd_valid[2], rd_valid[0]}), 128'(0));

    // 4: read-before-write collision
    step(4'b0001, {96'd0, 32'h0C}, 1'b1, 5'd3, 32'hAAAA5555, "t4a");
    chk("t4_old", 128'(rd_data[31:0]), 128'(32'h0000F020));
    step(4'b0001, {96'd0, 32'h0C}, 1'b0, 5'd0, 32'd0, "t4b");
    chk("t4_new", 128'(rd_data[31:0]), 128'(32'hAAAA5555));

    // 5: HALT detection is per core and sticky
    step(4'b0000, 128'd0, 1'b1, 5'd23, 32'hFC00F020, "t5w");
    step(4'b0010, {64'd0, 32'h5C, 32'd0}, 1'b0, 5'd0, 32'd0, "t5r");
    chk("t5_halt", 128'(halt_seen), 128'(4'b0010));
    step(4'b0000, 128'd0, 1'b0, 5'd0, 32'd0, "t5i");
    step(4'b1111, {4{32'h10}}, 1'b0, 5'd0, 32'd0, "t5s");
    chk("t5_sticky", 128'(halt_seen), 128'(4'b0010));

    // random traffic: mixed addresses, back-to-back loads, occasional HALT words
    repeat (300) begin
      wd = ($urandom_range(0, 7) == 0) ? {6'd63, 26'($urandom)} : $urandom;
      step(4'($urandom_range(0, 15)), {rand_addr(), rand_addr(), rand_addr(), rand_addr()},
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), wd, "rnd");
    end

    // 6: reset mid-read, then again mid-sweep
    step(4'b0000, 128'd0, 1'b1, 5'd8, 32'h8C030080, "t6w");
    do_reset(2, 4'b1111);
    reset_n = 1'b1;
    repeat (10) begin
      chk("t6_part_busy", 128'(busy), 128'(1));
      tick();
      chk("t6_part_valid", 128'(rd_valid), 128'(0));
    end
    do_reset(1, 4'b0000);
    reset_n = 1'b1;
    wait_sweep(n);
    chk("t6_sweep_len", 128'(n), 128'(32));
    step(4'b0100, {32'h0, 32'h20, 64'h0}, 1'b0, 5'd0, 32'd0, "t6r");
    chk("t6_word8", 128'(rd_data[95:64]), 128'(32'h0000F020));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
